// File: rtl/tl_pkg.sv
// TileLink-UH channel types and opcodes shared by the TL bridges,
// plus the burst-length helper used when mapping TL sizes onto a bus.
package tl_pkg;
  localparam int TlAddrWidth   = 56;
  localparam int TlDataWidth   = 64;
  localparam int TlSizeWidth   = 3;
  localparam int TlSourceWidth = 1;
  localparam int TlSinkWidth   = 1;
  localparam int TlMaskWidth   = TlDataWidth / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tl_d_op_e;

  typedef struct packed {
    logic                     a_valid;
    tl_a_op_e                 a_opcode;
    logic [2:0]               a_param;
    logic [TlSizeWidth-1:0]   a_size;
    logic [TlSourceWidth-1:0] a_source;
    logic [TlAddrWidth-1:0]   a_address;
    logic [TlMaskWidth-1:0]   a_mask;
    logic [TlDataWidth-1:0]   a_data;
    logic                     d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                     d_valid;
    tl_d_op_e                 d_opcode;
    logic [2:0]               d_param;
    logic [TlSizeWidth-1:0]   d_size;
    logic [TlSourceWidth-1:0] d_source;
    logic [TlSinkWidth-1:0]   d_sink;
    logic                     d_denied;
    logic [TlDataWidth-1:0]   d_data;
    logic                     d_corrupt;
    logic                     a_ready;
    logic                     b_valid;
    logic                     c_ready;
    logic                     e_ready;
  } tl_d2h_t;

  // Bus beats needed for a 2^size byte transfer; saturates at the AXI4 limit of 256.
  function automatic logic [8:0] burst_beats(input int size, input int bus_bytes_log2);
    if (size <= bus_bytes_log2) return 9'd1;
    else if (size - bus_bytes_log2 >= 8) return 9'd256;
    else return 9'(1 << (size - bus_bytes_log2));
  endfunction
endpackage

// File: rtl/axi_channel.sv
// AXI4 channel bundle; the master modport is the side that issues transactions.
interface axi_channel #(
  parameter int IdWidth   = 1,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64
);
  logic [IdWidth-1:0]     aw_id;
  logic [AddrWidth-1:0]   aw_addr;
  logic [7:0]             aw_len;
  logic [2:0]             aw_size;
  logic [1:0]             aw_burst;
  logic                   aw_lock;
  logic [3:0]             aw_cache;
  logic [2:0]             aw_prot;
  logic [3:0]             aw_qos;
  logic [3:0]             aw_region;
  logic                   aw_user;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_last;
  logic                   w_user;
  logic                   w_valid;
  logic                   w_ready;
  logic [IdWidth-1:0]     b_id;
  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;
  logic [IdWidth-1:0]     ar_id;
  logic [AddrWidth-1:0]   ar_addr;
  logic [7:0]             ar_len;
  logic [2:0]             ar_size;
  logic [1:0]             ar_burst;
  logic                   ar_lock;
  logic [3:0]             ar_cache;
  logic [2:0]             ar_prot;
  logic [3:0]             ar_qos;
  logic [3:0]             ar_region;
  logic                   ar_user;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [IdWidth-1:0]     r_id;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_last;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );
endinterface

// File: rtl/tl_axi_adapter.sv
// TL-UH to AXI4 bridge, one transaction in flight. Unsupported requests are
// drained on A and answered with a denied D response without touching AXI.
//   state      | meaning
//   StIdle     | wait for an A request, latch its header
//   StAr       | issue AR; the Get is consumed on the AR handshake
//   StRdata    | forward R beats to D until r_last
//   StAw       | issue AW
//   StWdata    | forward A data beats to W
//   StBresp    | wait for B, capture denied
//   StDack     | single AccessAck on D
//   StErrDrain | swallow the A beats of an unsupported request
//   StErrAck   | denied response on D
module tl_axi_adapter
  import tl_pkg::*;
#(
  parameter int IdWidth     = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SizeWidth   = 3,
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  tl_h2d_t    tl_h2d_i,
  output tl_d2h_t    tl_d2h_o,
  axi_channel.master axi
);
  localparam int BusLg   = $clog2(DataWidth / 8);
  localparam int MaxSize = $clog2(256 * DataWidth / 8);

  typedef enum logic [3:0] {
    StIdle, StAr, StRdata, StAw, StWdata, StBresp, StDack, StErrDrain, StErrAck
  } state_e;

  state_e                 state_q, state_d;
  logic [8:0]             cnt_q, beats_q, drain_beats, resp_beats;
  logic [7:0]             len;
  tl_a_op_e               op_q;
  logic [SizeWidth-1:0]   size_q;
  logic [SourceWidth-1:0] source_q;
  logic [AddrWidth-1:0]   addr_q;
  logic                   denied_q;
  logic [2:0]             ax_size;
  logic                   op_has_data, op_atomic, hs;
  logic                   a_ready, ar_valid, aw_valid, w_valid, w_last, b_ready, r_ready;
  logic                   d_valid, d_denied, d_corrupt;
  tl_d_op_e               d_opcode;
  logic [DataWidth-1:0]   d_data;
  logic                   unused_sigs;

  assign len         = 8'(beats_q - 9'd1);
  assign ax_size     = (int'(size_q) > BusLg) ? 3'(BusLg) : 3'(size_q);
  assign op_has_data = op_q inside {PutFullData, PutPartialData, ArithmeticData, LogicalData};
  assign op_atomic   = op_q inside {ArithmeticData, LogicalData};
  assign drain_beats = op_has_data ? beats_q : 9'd1;
  assign resp_beats  = op_atomic ? beats_q : 9'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      beats_q  <= 9'd1;
      op_q     <= Get;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (hs)            cnt_q <= cnt_q + 9'd1;
      if (state_q == StIdle && tl_h2d_i.a_valid) begin
        op_q     <= tl_h2d_i.a_opcode;
        size_q   <= tl_h2d_i.a_size;
        source_q <= tl_h2d_i.a_source;
        addr_q   <= tl_h2d_i.a_address;
        beats_q  <= burst_beats(int'(tl_h2d_i.a_size), BusLg);
      end
      if (state_q == StBresp && axi.b_valid) denied_q <= axi.b_resp[1];
    end
  end

  always_comb begin
    state_d   = state_q;
    hs        = 1'b0;
    a_ready   = 1'b0;
    ar_valid  = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    b_ready   = 1'b0;
    r_ready   = 1'b0;
    d_valid   = 1'b0;
    d_opcode  = AccessAck;
    d_data    = '0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tl_h2d_i.a_valid) begin
          if (int'(tl_h2d_i.a_size) > MaxSize) state_d = StErrDrain;
          else begin
            unique case (tl_h2d_i.a_opcode)
              Get:                         state_d = StAr;
              PutFullData, PutPartialData: state_d = StAw;
              default:                     state_d = StErrDrain;
            endcase
          end
        end
      end
      StAr: begin
        ar_valid = 1'b1;
        a_ready  = axi.ar_ready;
        if (axi.ar_ready) state_d = StRdata;
      end
      StRdata: begin
        d_valid   = axi.r_valid;
        r_ready   = tl_h2d_i.d_ready;
        d_opcode  = AccessAckData;
        d_data    = axi.r_data;
        d_denied  = axi.r_resp[1];
        d_corrupt = axi.r_resp[1];
        hs        = axi.r_valid && tl_h2d_i.d_ready;
        if (hs && axi.r_last) state_d = StIdle;
      end
      StAw: begin
        aw_valid = 1'b1;
        if (axi.aw_ready) state_d = StWdata;
      end
      StWdata: begin
        w_valid = tl_h2d_i.a_valid;
        a_ready = axi.w_ready;
        w_last  = (cnt_q == {1'b0, len});
        hs      = tl_h2d_i.a_valid && axi.w_ready;
        if (hs && w_last) state_d = StBresp;
      end
      StBresp: begin
        b_ready = 1'b1;
        if (axi.b_valid) state_d = StDack;
      end
      StDack: begin
        d_valid  = 1'b1;
        d_denied = denied_q;
        if (tl_h2d_i.d_ready) state_d = StIdle;
      end
      StErrDrain: begin
        a_ready = 1'b1;
        hs      = tl_h2d_i.a_valid;
        if (hs && cnt_q == drain_beats - 9'd1) state_d = StErrAck;
      end
      StErrAck: begin
        d_valid  = 1'b1;
        d_denied = 1'b1;
        if (op_atomic) begin
          d_opcode  = AccessAckData;
          d_corrupt = 1'b1;
        end else if (op_q == Intent) begin
          d_opcode = HintAck;
        end
        hs = tl_h2d_i.d_ready;
        if (hs && cnt_q == resp_beats - 9'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tl_d2h_o           = '0;
    tl_d2h_o.a_ready   = a_ready;
    tl_d2h_o.d_valid   = d_valid;
    tl_d2h_o.d_opcode  = d_opcode;
    tl_d2h_o.d_param   = 3'd0;
    tl_d2h_o.d_size    = size_q;
    tl_d2h_o.d_source  = source_q;
    tl_d2h_o.d_sink    = {SinkWidth{1'b0}};
    tl_d2h_o.d_denied  = d_denied;
    tl_d2h_o.d_data    = d_data;
    tl_d2h_o.d_corrupt = d_corrupt;
    tl_d2h_o.b_valid   = 1'b0;
    tl_d2h_o.c_ready   = 1'b1;
    tl_d2h_o.e_ready   = 1'b1;
  end

  assign axi.ar_id     = {IdWidth{1'b0}};
  assign axi.ar_addr   = addr_q;
  assign axi.ar_len    = len;
  assign axi.ar_size   = ax_size;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'd0;
  assign axi.ar_prot   = 3'd0;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_user   = 1'b0;
  assign axi.ar_valid  = ar_valid;
  assign axi.aw_id     = {IdWidth{1'b0}};
  assign axi.aw_addr   = addr_q;
  assign axi.aw_len    = len;
  assign axi.aw_size   = ax_size;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'd0;
  assign axi.aw_prot   = 3'd0;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_user   = 1'b0;
  assign axi.aw_valid  = aw_valid;
  assign axi.w_data    = tl_h2d_i.a_data;
  assign axi.w_strb    = tl_h2d_i.a_mask;
  assign axi.w_last    = w_last;
  assign axi.w_user    = 1'b0;
  assign axi.w_valid   = w_valid;
  assign axi.b_ready   = b_ready;
  assign axi.r_ready   = r_ready;

  assign unused_sigs = ^{tl_h2d_i.a_param, axi.r_id, axi.b_id, axi.r_resp[0], axi.b_resp[0]};
endmodule

// File: tb/tb_tl_axi_adapter.sv
// Directed bench for tl_axi_adapter: a table of TL requests run against a
// simple AXI slave, plus hand sequences for reset behaviour.
module tb_tl_axi_adapter;
  import tl_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t h2d;
  tl_d2h_t d2h;
  int      n_checks = 0;
  int      n_pass = 0;

  axi_channel axi_if ();

  tl_axi_adapter dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tl_h2d_i(h2d),
    .tl_d2h_o(d2h),
    .axi     (axi_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          op;
    int          size;
    logic [55:0] addr;
    logic [7:0]  mask;
    logic [63:0] dbase;
    logic [1:0]  resp;
    bit          stall;
    int          e_ar, e_aw, e_len, e_axsize, e_a, e_w, e_d, e_dop;
    int          e_denied, e_corrupt;
    logic [63:0] e_data0;
  } vec_t;

  vec_t vecs[10];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  function automatic logic [6:0] valids();
    return {axi_if.ar_valid, axi_if.aw_valid, axi_if.w_valid, axi_if.b_ready,
            axi_if.r_ready, d2h.a_ready, d2h.d_valid};
  endfunction

  task automatic run_txn(input vec_t v);
    int ar_n = 0, aw_n = 0, ax_len = -1, ax_sz = -1, a_n = 0, w_n = 0, d_n = 0, r_n = 0;
    int last_err = 0, data_err = 0, stall_err = 0, stall_cnt = 0, extra_d = 0, cyc = 0;
    int r_len = 0, dop = -1, den = -1, cor = -1, a_ready_first = -1;
    bit b_pend = 0, r_act = 0;
    logic [55:0] ax_addr = '0;
    logic [63:0] d0 = '0;
    h2d.a_opcode = tl_a_op_e'(v.op);
    h2d.a_size   = 3'(v.size);
    h2d.a_address = v.addr;
    h2d.a_mask   = v.mask;
    h2d.a_source = 1'b1;
    while (d_n < v.e_d && cyc < 300) begin
      h2d.a_valid      = (a_n < v.e_a);
      h2d.a_data       = v.dbase + 64'(a_n);
      axi_if.r_valid   = r_act && (r_n <= r_len);
      axi_if.r_data    = v.dbase + 64'(r_n);
      axi_if.r_last    = (r_n == r_len);
      axi_if.r_resp    = v.resp;
      axi_if.b_valid   = b_pend;
      axi_if.b_resp    = v.resp;
      h2d.d_ready      = !(v.stall && d_n == 3 && stall_cnt < 3);
      #1;
      if (cyc == 0) a_ready_first = int'(d2h.a_ready);
      if (axi_if.ar_valid && axi_if.ar_ready) begin
        ar_n++; ax_len = int'(axi_if.ar_len); ax_sz = int'(axi_if.ar_size);
        ax_addr = axi_if.ar_addr; r_act = 1; r_len = ax_len; r_n = 0;
      end
      if (axi_if.aw_valid && axi_if.aw_ready) begin
        aw_n++; ax_len = int'(axi_if.aw_len); ax_sz = int'(axi_if.aw_size);
        ax_addr = axi_if.aw_addr;
      end
      if (h2d.a_valid && d2h.a_ready) a_n++;
      if (axi_if.w_valid && axi_if.w_ready) begin
        if (axi_if.w_last !== (w_n == v.e_w - 1)) last_err++;
        if (axi_if.w_strb !== v.mask || axi_if.w_data !== v.dbase + 64'(w_n)) data_err++;
        if (axi_if.w_last) b_pend = 1;
        w_n++;
      end
      if (axi_if.b_valid && axi_if.b_ready) b_pend = 0;
      if (!h2d.d_ready) begin
        stall_cnt++;
        if (axi_if.r_ready) stall_err++;
      end
      if (d2h.d_valid && h2d.d_ready) begin
        if (d_n == 0) begin
          dop = int'(d2h.d_opcode); den = int'(d2h.d_denied); cor = int'(d2h.d_corrupt);
          d0 = d2h.d_data;
        end else if (int'(d2h.d_opcode) != dop || int'(d2h.d_denied) != den) data_err++;
        if (ar_n > 0 && d2h.d_data !== v.dbase + 64'(d_n)) data_err++;
        if (d2h.d_size !== 3'(v.size) || d2h.d_source !== 1'b1) data_err++;
        d_n++;
      end
      if (axi_if.r_valid && axi_if.r_ready) r_n++;
      @(posedge clk); #1;
      cyc++;
    end
    h2d.a_valid = 0; axi_if.r_valid = 0; axi_if.b_valid = 0; h2d.d_ready = 1;
    repeat (3) begin
      #1;
      if (d2h.d_valid || d2h.a_ready) extra_d++;
      @(posedge clk); #1;
    end
    chk({v.name, "/no_timeout"}, 64'(cyc < 300), 64'd1);
    chk({v.name, "/idle_no_aready"}, 64'(a_ready_first), 64'd0);
    chk({v.name, "/ar_count"}, 64'(ar_n), 64'(v.e_ar));
    chk({v.name, "/aw_count"}, 64'(aw_n), 64'(v.e_aw));
    chk({v.name, "/ax_len"}, 64'(ax_len), 64'(v.e_len));
    chk({v.name, "/ax_size"}, 64'(ax_sz), 64'(v.e_axsize));
    chk({v.name, "/ax_addr"}, 64'(ax_addr), (v.e_ar + v.e_aw > 0) ? 64'(v.addr) : 64'd0);
    chk({v.name, "/a_beats"}, 64'(a_n), 64'(v.e_a));
    chk({v.name, "/w_beats"}, 64'(w_n), 64'(v.e_w));
    chk({v.name, "/d_beats"}, 64'(d_n), 64'(v.e_d));
    chk({v.name, "/d_opcode"}, 64'(dop), 64'(v.e_dop));
    chk({v.name, "/d_denied"}, 64'(den), 64'(v.e_denied));
    chk({v.name, "/d_corrupt"}, 64'(cor), 64'(v.e_corrupt));
    chk({v.name, "/d_data0"}, d0, v.e_data0);
    chk({v.name, "/w_last_pos"}, 64'(last_err), 64'd0);
    chk({v.name, "/beat_fields"}, 64'(data_err), 64'd0);
    chk({v.name, "/stall_r_ready"}, 64'(stall_err), 64'd0);
    chk({v.name, "/stall_cycles"}, 64'(stall_cnt), v.stall ? 64'd3 : 64'd0);
    chk({v.name, "/quiet_after"}, 64'(extra_d), 64'd0);
  endtask

  initial begin
    vec_t v;
    int w_seen, cyc;
    //          name             op sz addr     mask   dbase                   rsp st ar aw len asz a  w  d  dop den cor data0
    vecs[0] = '{"get8",          4, 3, 56'h80,  8'hFF, 64'hDEADBEEF,           0, 0, 1, 0, 0, 3, 1, 0, 1, 1, 0, 0, 64'hDEADBEEF};
    vecs[1] = '{"get64_stall",   4, 6, 56'h1000,8'hFF, 64'h1111_0000_0000_0000,0, 1, 1, 0, 7, 3, 1, 0, 8, 1, 0, 0, 64'h1111_0000_0000_0000};
    vecs[2] = '{"putp4",         1, 2, 56'h204, 8'h0F, 64'hCAFE_F00D,          0, 0, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0, 64'h0};
    vecs[3] = '{"putf64_slverr", 0, 6, 56'h2000,8'hFF, 64'hA5A5_0000_0000_0000,2, 0, 0, 1, 7, 3, 8, 8, 1, 0, 1, 0, 64'h0};
    vecs[4] = '{"arith16",       2, 4, 56'h300, 8'hFF, 64'h55,                 0, 0, 0, 0,-1,-1, 2, 0, 2, 1, 1, 1, 64'h0};
    vecs[5] = '{"get_slverr",    4, 3, 56'h88,  8'hFF, 64'h1234,               2, 0, 1, 0, 0, 3, 1, 0, 1, 1, 1, 1, 64'h1234};
    vecs[6] = '{"intent",        5, 2, 56'h40,  8'hFF, 64'h0,                  0, 0, 0, 0,-1,-1, 1, 0, 1, 2, 1, 0, 64'h0};
    vecs[7] = '{"logical8",      3, 3, 56'h48,  8'hFF, 64'h77,                 0, 0, 0, 0,-1,-1, 1, 0, 1, 1, 1, 1, 64'h0};
    vecs[8] = '{"get1",          4, 0, 56'h91,  8'hFF, 64'hAB,                 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 64'hAB};
    vecs[9] = '{"putf16_exok",   0, 4, 56'h400, 8'hFF, 64'h9,                  1, 0, 0, 1, 1, 3, 2, 2, 1, 0, 0, 0, 64'h0};

    h2d = '0;
    h2d.a_valid = 1'b1;
    h2d.d_ready = 1'b1;
    axi_if.ar_ready = 1'b1; axi_if.aw_ready = 1'b1; axi_if.w_ready = 1'b1;
    axi_if.r_valid = 1'b0; axi_if.r_id = '0; axi_if.r_data = '0; axi_if.r_resp = '0; axi_if.r_last = 1'b0;
    axi_if.b_valid = 1'b0; axi_if.b_id = '0; axi_if.b_resp = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset/valids", 64'(valids()), 64'd0);
    chk("reset/tieoffs", 64'({d2h.b_valid, d2h.c_ready, d2h.e_ready, d2h.d_sink, d2h.d_param}), 64'b0110000);
    h2d.a_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle/valids", 64'(valids()), 64'd0);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset in the middle of a write burst.
    h2d.a_opcode = PutFullData; h2d.a_size = 3'd6; h2d.a_address = 56'h3000;
    h2d.a_mask = 8'hFF; h2d.a_data = 64'h0; h2d.a_valid = 1'b1;
    w_seen = 0; cyc = 0;
    while (w_seen < 3 && cyc < 50) begin
      #1;
      if (axi_if.w_valid && axi_if.w_ready) w_seen++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid/reached_wdata", 64'(w_seen), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid/valids_now", 64'(valids()), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mid/valids_held", 64'(valids()), 64'd0);
    end
    h2d.a_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid/no_d_after", 64'(valids()), 64'd0);
    v = vecs[0];
    v.name = "post_rst_get8";
    run_txn(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
